// File: rtl/alu_request_ctrl.sv
// ALU/shifter request controller: decodes R/I-type op, issues to the logic unit, waits for Update_UC.
// Latency: start to done = 3 + (WAIT cycles) cycles; 2 cycles for an illegal op.
// Backpressure: one request in flight; start is only sampled in IDLE, otherwise dropped.
module alu_request_ctrl #(
  parameter int DATA_W  = 33,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt_in,
  output logic [3:0]        ALUOp,
  output logic [4:0]        SHAMT,
  output logic              ALUSrcB_sel,
  input  logic              Update_UC,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              OVERFLOW,
  input  logic              ZERO,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken,
  output logic              exc_ovf,
  output logic              err_timeout,
  output logic              illegal_op
);

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011, OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010, OP_SLT = 4'b1011;
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [5:0]  op_q, funct_q;
  logic [4:0]  shamt_q;
  logic [3:0]  cnt;
  logic [3:0]  dec_op;
  logic [4:0]  dec_shamt;
  logic        dec_imm, dec_ovf, dec_beq, dec_bne, dec_legal;
  logic        timeout_hit;

  // Decode works on the latched instruction fields, never on the live inputs.
  always_comb begin
    dec_op    = 4'b0000;
    dec_shamt = 5'd0;
    dec_imm   = 1'b0;
    dec_ovf   = 1'b0;
    dec_beq   = 1'b0;
    dec_bne   = 1'b0;
    dec_legal = 1'b1;
    if (op_q == 6'h00) begin
      case (funct_q)
        6'h20: begin dec_op = OP_ADD; dec_ovf = 1'b1; end
        6'h21: dec_op = OP_ADD;
        6'h22: begin dec_op = OP_SUB; dec_ovf = 1'b1; end
        6'h23: dec_op = OP_SUB;
        6'h24: dec_op = OP_AND;
        6'h25: dec_op = OP_OR;
        6'h2A: dec_op = OP_SLT;
        6'h00: begin dec_op = OP_SLL; dec_shamt = shamt_q; end
        6'h02: begin dec_op = OP_SRL; dec_shamt = shamt_q; end
        6'h03: begin dec_op = OP_SRA; dec_shamt = shamt_q; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (op_q)
        6'h08: begin dec_op = OP_ADD; dec_imm = 1'b1; dec_ovf = 1'b1; end
        6'h09: begin dec_op = OP_ADD; dec_imm = 1'b1; end
        6'h04: begin dec_op = OP_SUB; dec_beq = 1'b1; end
        6'h05: begin dec_op = OP_SUB; dec_bne = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign timeout_hit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec_legal ? S_ISSUE : S_RESP;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (Update_UC || timeout_hit) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ALUOp       = 4'b0000;
    SHAMT       = 5'd0;
    ALUSrcB_sel = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    if (state == S_ISSUE || state == S_WAIT) begin
      ALUOp       = dec_op;
      SHAMT       = dec_shamt;
      ALUSrcB_sel = dec_imm;
    end
    if (state == S_ISSUE || state == S_WAIT || state == S_RESP) busy = 1'b1;
    if (state == S_RESP) done = 1'b1;
  end

  // Flags are only ever nonzero while in RESP; result persists across requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= 6'd0;
      funct_q      <= 6'd0;
      shamt_q      <= 5'd0;
      cnt          <= 4'd0;
      result       <= '0;
      branch_taken <= 1'b0;
      exc_ovf      <= 1'b0;
      err_timeout  <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q    <= opcode;
          funct_q <= funct;
          shamt_q <= shamt_in;
        end
        S_DECODE: if (!dec_legal) illegal_op <= 1'b1;
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (Update_UC) begin
            result       <= ALUOut;
            exc_ovf      <= OVERFLOW & dec_ovf;
            branch_taken <= (dec_beq & ZERO) | (dec_bne & ~ZERO);
            cnt          <= 4'd0;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            cnt         <= 4'd0;
          end
        end
        S_RESP: begin
          branch_taken <= 1'b0;
          exc_ovf      <= 1'b0;
          err_timeout  <= 1'b0;
          illegal_op   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_ctrl.sv
// Bench for alu_request_ctrl: vector table with a done-time scoreboard plus reset/restart sequences.
module tb_alu_request_ctrl;
  localparam int DATA_W  = 33;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset, start, Update_UC, OVERFLOW, ZERO;
  logic [5:0]        opcode, funct;
  logic [4:0]        shamt_in, SHAMT;
  logic [3:0]        ALUOp;
  logic              ALUSrcB_sel, busy, done, branch_taken, exc_ovf, err_timeout, illegal_op;
  logic [DATA_W-1:0] ALUOut, result;

  alu_request_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .shamt_in(shamt_in), .ALUOp(ALUOp), .SHAMT(SHAMT), .ALUSrcB_sel(ALUSrcB_sel),
    .Update_UC(Update_UC), .ALUOut(ALUOut), .OVERFLOW(OVERFLOW), .ZERO(ZERO),
    .busy(busy), .done(done), .result(result), .branch_taken(branch_taken),
    .exc_ovf(exc_ovf), .err_timeout(err_timeout), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [32:0] out;
    logic        ovf, zero;
    int          uck;      // WAIT cycle carrying Update_UC, 0 = never
    logic        rs;       // re-assert start while busy
    logic [3:0]  e_op;
    logic [4:0]  e_sh;
    logic        e_src, e_br, e_exc, e_ill;
  } vec_t;

  typedef struct {
    int          lat;
    logic [32:0] res;
    logic        br, exc, tmo, ill;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sbq[$];
  logic [32:0] last_res;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [32:0] out, input logic ovf, input logic zero,
                              input int uck, input logic rs, input logic [3:0] e_op,
                              input logic [4:0] e_sh, input logic e_src, input logic e_br,
                              input logic e_exc, input logic e_ill);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.out = out; v.ovf = ovf; v.zero = zero;
    v.uck = uck; v.rs = rs; v.e_op = e_op; v.e_sh = e_sh; v.e_src = e_src;
    v.e_br = e_br; v.e_exc = e_exc; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e, p;
    bit          got;
    bit          stable;
    logic [3:0]  seen_op;
    logic [4:0]  seen_sh;
    logic        seen_src;
    int          dn;
    e.ill = v.e_ill;
    e.tmo = !v.e_ill && v.uck == 0;
    e.lat = v.e_ill ? 2 : (v.uck == 0 ? 3 + TIMEOUT : 3 + v.uck);
    e.res = (!v.e_ill && v.uck != 0) ? v.out : last_res;
    e.br  = v.e_br;
    e.exc = v.e_exc;
    last_res = e.res;
    sbq.push_back(e);

    @(negedge clk);
    start = 1'b1; opcode = v.op; funct = v.fn; shamt_in = v.sh;
    got = 0; stable = 1; seen_op = 4'd0; seen_sh = 5'd0; seen_src = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      start = v.rs && (cyc == 2 || cyc == 3);
      opcode = 6'($urandom); funct = 6'($urandom); shamt_in = 5'($urandom);
      if (ALUOp != 4'd0) begin
        if (seen_op == 4'd0) begin
          seen_op = ALUOp; seen_sh = SHAMT; seen_src = ALUSrcB_sel;
        end else if ({ALUOp, SHAMT, ALUSrcB_sel} !== {seen_op, seen_sh, seen_src}) stable = 0;
      end
      if (done) begin
        got = 1;
        p = sbq.pop_front();
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(p.lat));
        chk($sformatf("v%0d_result", idx), 64'(result), 64'(p.res));
        chk($sformatf("v%0d_flags{br,exc,tmo,ill,busy}", idx),
            64'({branch_taken, exc_ovf, err_timeout, illegal_op, busy}),
            64'({p.br, p.exc, p.tmo, p.ill, 1'b1}));
      end
      if (v.uck != 0 && cyc == 2 + v.uck) begin
        Update_UC = 1'b1; ALUOut = v.out; OVERFLOW = v.ovf; ZERO = v.zero;
      end else begin
        Update_UC = 1'b0; ALUOut = 33'($urandom); OVERFLOW = 1'($urandom); ZERO = 1'($urandom);
      end
    end
    if (!got) chk($sformatf("v%0d_done_seen", idx), 64'd0, 64'd1);
    chk($sformatf("v%0d_issue{op,sh,src}", idx), 64'({seen_op, seen_sh, seen_src}),
        64'({v.e_op, v.e_sh, v.e_src}));
    chk($sformatf("v%0d_aluop_stable", idx), 64'(stable), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_after{done,busy,flags,op}", idx),
        64'({done, busy, branch_taken, exc_ovf, err_timeout, illegal_op, ALUOp}), 64'd0);
    if (v.rs) begin
      dn = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk($sformatf("v%0d_no_restart_done", idx), 64'(dn), 64'd0);
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0; shamt_in = '0;
    Update_UC = 1'b0; ALUOut = '0; OVERFLOW = 1'b0; ZERO = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({ALUOp, SHAMT, ALUSrcB_sel, busy, done, branch_taken, exc_ovf,
                              err_timeout, illegal_op}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    reset = 1'b0;

    //           op     fn     sh     out             ovf zr uck rs  e_op   e_sh src br exc ill
    vecs.push_back(mk(6'h00, 6'h20, 5'd3,  33'd5,          0, 0, 1, 0, 4'h1, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h20, 5'd0,  33'h1_0000_0007, 1, 0, 1, 0, 4'h1, 5'd0,  0, 0, 1, 0));
    vecs.push_back(mk(6'h00, 6'h21, 5'd0,  33'h0_8000_0000, 1, 0, 2, 0, 4'h1, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(6'h04, 6'h11, 5'd9,  33'd0,          0, 1, 1, 0, 4'h2, 5'd0,  0, 1, 0, 0));
    vecs.push_back(mk(6'h05, 6'h00, 5'd0,  33'd0,          0, 1, 1, 0, 4'h2, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(6'h05, 6'h00, 5'd0,  33'd12,         1, 0, 1, 0, 4'h2, 5'd0,  0, 1, 0, 0));
    vecs.push_back(mk(6'h00, 6'h02, 5'd7,  33'h0_0123_4567, 0, 0, 1, 0, 4'h9, 5'd7,  0, 0, 0, 0));
    vecs.push_back(mk(6'h3F, 6'h20, 5'd0,  33'd99,         0, 0, 0, 0, 4'h0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(6'h00, 6'h22, 5'd0,  33'h1_FFFF_FFFF, 1, 0, 3, 0, 4'h2, 5'd0,  0, 0, 1, 0));
    vecs.push_back(mk(6'h08, 6'h3F, 5'd1,  33'h0_7FFF_FFFF, 1, 0, 1, 0, 4'h1, 5'd0,  1, 0, 1, 0));
    vecs.push_back(mk(6'h09, 6'h00, 5'd0,  33'd42,         1, 0, 2, 0, 4'h1, 5'd0,  1, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h24, 5'd0,  33'd77,         0, 0, 0, 0, 4'h3, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h2A, 5'd0,  33'd1,          1, 1, 15, 0, 4'hB, 5'd0, 0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h03, 5'd31, 33'h1_2345_6789, 0, 0, 1, 0, 4'hA, 5'd31, 0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h00, 5'd4,  33'd64,         0, 0, 1, 0, 4'h8, 5'd4,  0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h25, 5'd2,  33'd3,          0, 1, 4, 1, 4'h4, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h3F, 5'd0,  33'd8,          0, 0, 0, 0, 4'h0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(6'h00, 6'h23, 5'd0,  33'd9,          1, 0, 1, 0, 4'h2, 5'd0,  0, 0, 0, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    // Update_UC while idle must not touch the captured result.
    @(negedge clk);
    Update_UC = 1'b1; ALUOut = 33'h1_AAAA_5555; OVERFLOW = 1'b1;
    @(negedge clk);
    Update_UC = 1'b0;
    chk("idle_uc_ignored{done,result}", 64'({done, result}), 64'({1'b0, last_res}));

    // Synchronous reset while waiting: straight back to IDLE, no done afterwards.
    start = 1'b1; opcode = 6'h00; funct = 6'h20; shamt_in = 5'd0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 64'({busy, done, ALUOp, SHAMT, ALUSrcB_sel}), 64'd0);
    chk("midreset_result", 64'(result), 64'd0);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midreset_no_done", 64'(dn), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
